lane_burst_arbiter: RTL and testbench

//  Round-robin burst arbiter sharing one output bus between LANES generate-built

---
 rtl/lane_burst_arbiter.sv | 129 ++++++++++++
 tb/tb_lane_burst_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_burst_arbiter.sv
// Round-robin burst arbiter: graded-width requester lanes share one zero-extended output bus.
// Optional per-lane grant counters are built when LANE_BURST_ARBITER_STATS_EN is defined.
module lane_burst_arbiter #(
  parameter int unsigned LANES     = 3,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LANES-1:0]                       req,
  input  logic [LANES-1:0]                       last,
  input  logic [LANES*LANES-1:0]                 in_data,
  output logic [LANES-1:0]                       gnt,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
  output logic [2*LANES-2:0]                     out_data,
  output logic [8*LANES-1:0]                     grant_cnt
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DataW = 2 * LANES - 1;
  localparam int unsigned BeatW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [LaneW-1:0]   rr_q, rr_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LANES-1:0]   gnt_q, gnt_d;
  logic               grant_fire;

  // Lane i occupies [i*i +: 2*i+1]; widen every slice to the bus width once.
  logic [DataW-1:0] lane_ext [LANES];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_ext[g] = DataW'(in_data[g*g +: 2*g+1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      lane_q  <= '0;
      beat_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    logic             found;
    logic             rel;
    logic [LaneW-1:0] sel;
    logic [LaneW-1:0] idx;
    state_d    = state_q;
    rr_d       = rr_q;
    lane_d     = lane_q;
    beat_d     = beat_q;
    gnt_d      = gnt_q;
    grant_fire = 1'b0;
    found      = 1'b0;
    rel        = 1'b0;
    sel        = rr_q;
    idx        = '0;
    // First set request at or above the pointer, wrapping past the top lane.
    for (int k = 0; k < LANES; k++) begin
      idx = LaneW'((int'(rr_q) + k) % LANES);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StBusy;
          lane_d     = sel;
          gnt_d      = LANES'(1) << sel;
          beat_d     = '0;
          grant_fire = 1'b1;
        end
      end
      StBusy: begin
        if (!req[lane_q]) begin
          rel = 1'b1;
        end else if (out_ready) begin
          if (last[lane_q] || (beat_q == BeatW'(BURST_MAX - 1))) rel = 1'b1;
          else beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rel) begin
      state_d = StIdle;
      gnt_d   = '0;
      beat_d  = '0;
      rr_d    = (lane_q == LaneW'(LANES - 1)) ? '0 : lane_q + 1'b1;
    end
  end

  always_comb begin
    gnt       = gnt_q;
    out_lane  = lane_q;
    out_valid = (state_q == StBusy) && req[lane_q];
    out_data  = out_valid ? lane_ext[lane_q] : '0;
  end

`ifdef LANE_BURST_ARBITER_STATS_EN
  for (genvar g = 0; g < LANES; g++) begin : g_stats
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (grant_fire && (lane_d == LaneW'(g)) && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
    assign grant_cnt[8*g +: 8] = cnt_q;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_burst_arbiter.sv
// Self-checking bench for lane_burst_arbiter (LANES=3, BURST_MAX=4): directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_lane_burst_arbiter;

  localparam int L  = 3;
  localparam int BM = 4;

  logic         clk;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   last;
  logic [8:0]   in_data;
  logic [2:0]   gnt;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_lane;
  logic [4:0]   out_data;
  logic [23:0]  grant_cnt;

  int checks;
  int failures;

  // Reference model: who owns the bus, how many beats moved, whose turn is next.
  bit         m_busy;
  int         m_lane;
  int         m_beats;
  int         m_ptr;
  logic [7:0] m_cnt [3];

  lane_burst_arbiter #(.LANES(L), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_data  (out_data),
    .grant_cnt (grant_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_step();
    bit rel;
    rel = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_lane = 0; m_beats = 0; m_ptr = 0;
      for (int i = 0; i < L; i++) m_cnt[i] = 8'h00;
    end else if (!m_busy) begin
      for (int k = 0; k < L; k++) begin
        int c;
        c = (m_ptr + k) % L;
        if (!m_busy && req[c]) begin
          m_busy = 1'b1; m_lane = c; m_beats = 0;
          if (m_cnt[c] != 8'hFF) m_cnt[c] = m_cnt[c] + 8'd1;
        end
      end
    end else begin
      if (!req[m_lane]) rel = 1'b1;
      else if (out_ready) begin
        m_beats++;
        if (last[m_lane] || m_beats == BM) rel = 1'b1;
      end
      if (rel) begin
        m_busy = 1'b0; m_beats = 0; m_ptr = (m_lane + 1) % L;
      end
    end
  endfunction

  function automatic logic [2:0] m_gnt();
    return m_busy ? 3'(1 << m_lane) : 3'b000;
  endfunction

  function automatic logic m_valid();
    return m_busy && req[m_lane];
  endfunction

  function automatic logic [4:0] m_data();
    int w;
    int v;
    if (!m_valid()) return 5'd0;
    w = 2 * m_lane + 1;
    v = (int'(in_data) >> (m_lane * m_lane)) & ((1 << w) - 1);
    return 5'(v);
  endfunction

  function automatic logic [23:0] m_cnt_packed();
`ifdef LANE_BURST_ARBITER_STATS_EN
    return {m_cnt[2], m_cnt[1], m_cnt[0]};
`else
    return 24'd0;
`endif
  endfunction

  // Advance model and DUT across one rising edge; returns at the following negedge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; last = 3'b000; out_ready = 1'b1; in_data = '1;
    step();
    step();
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 5'd0) begin failures++; $display("FAIL reset_data got=%b exp=00000", out_data); end
    checks++;
    if (grant_cnt !== 24'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", grant_cnt); end
    rst = 1'b0; req = 3'b000;
    step();
  endtask

  task automatic test_single_lane2();
    req = 3'b100; last = 3'b100; out_ready = 1'b1; in_data = {5'b10101, 3'b000, 1'b0};
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL lane2_pre_gnt got=%b exp=000", gnt); end
    step();
    #1;
    checks++;
    if (gnt !== 3'b100) begin failures++; $display("FAIL lane2_gnt got=%b exp=100", gnt); end
    checks++;
    if (out_lane !== 2'd2) begin failures++; $display("FAIL lane2_lane got=%0d exp=2", out_lane); end
    checks++;
    if (out_data !== 5'b10101) begin failures++; $display("FAIL lane2_data got=%b exp=10101", out_data); end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL lane2_valid got=%b exp=1", out_valid); end
    step();
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL lane2_bubble got=%b exp=000", gnt); end
    req = 3'b000;
    step();
  endtask

  task automatic test_zero_extend();
    in_data = '1; last = 3'b111; out_ready = 1'b1;
    req = 3'b001;
    step();
    #1;
    checks++;
    if (out_data !== 5'b00001) begin failures++; $display("FAIL zext_lane0 got=%b exp=00001", out_data); end
    step();
    req = 3'b010;
    step();
    #1;
    checks++;
    if (out_data !== 5'b00111) begin failures++; $display("FAIL zext_lane1 got=%b exp=00111", out_data); end
    req = 3'b000;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [8];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    rst = 1'b1;
    step();
    rst = 1'b0; req = 3'b111; last = 3'b111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (gnt !== exp_g[c]) begin
        failures++; $display("FAIL rr_seq[%0d] got=%b exp=%b", c, gnt, exp_g[c]);
      end
      step();
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_burst_max();
    logic [2:0] eg;
    rst = 1'b1;
    step();
    rst = 1'b0; req = 3'b010; last = 3'b000;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c % 2 == 0);
      eg = (c == 0 || c == 9) ? 3'b000 : 3'b010;
      #1;
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (out_valid !== (eg != 3'b000)) begin
        failures++; $display("FAIL burst_valid[%0d] got=%b exp=%b", c, out_valid, eg != 3'b000);
      end
      step();
    end
    req = 3'b000;
    step();
    step();
  endtask

  task automatic test_stats();
    logic [7:0] exp_c;
`ifdef LANE_BURST_ARBITER_STATS_EN
    exp_c = 8'hFF;
`else
    exp_c = 8'h00;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0; req = 3'b001; last = 3'b001; out_ready = 1'b1;
    for (int c = 0; c < 600; c++) step();
    #1;
    checks++;
    if (grant_cnt[7:0] !== exp_c) begin
      failures++; $display("FAIL stats_sat got=%h exp=%h", grant_cnt[7:0], exp_c);
    end
    checks++;
    if (grant_cnt[23:8] !== 16'd0) begin
      failures++; $display("FAIL stats_other got=%h exp=0", grant_cnt[23:8]);
    end
    last = 3'b000;
    step();
    #1;
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL stats_busy got=%b exp=001", gnt); end
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL stats_rst_gnt got=%b exp=000", gnt); end
    checks++;
    if (grant_cnt !== 24'd0) begin failures++; $display("FAIL stats_rst_cnt got=%h exp=0", grant_cnt); end
    rst = 1'b0; req = 3'b000;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = 3'($urandom_range(0, 7));
      last      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 9'($urandom);
      #1;
      checks++;
      if (gnt !== m_gnt()) begin failures++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, gnt, m_gnt()); end
      checks++;
      if (out_valid !== m_valid()) begin
        failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid, m_valid());
      end
      checks++;
      if (out_data !== m_data()) begin
        failures++; $display("FAIL rnd_data[%0d] got=%b exp=%b", c, out_data, m_data());
      end
      if (m_busy) begin
        checks++;
        if (out_lane !== 2'(m_lane)) begin
          failures++; $display("FAIL rnd_lane[%0d] got=%0d exp=%0d", c, out_lane, m_lane);
        end
      end
      checks++;
      if (grant_cnt !== m_cnt_packed()) begin
        failures++; $display("FAIL rnd_cnt[%0d] got=%h exp=%h", c, grant_cnt, m_cnt_packed());
      end
      step();
    end
    rst = 1'b0; req = 3'b000;
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    m_busy = 1'b0; m_lane = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < L; i++) m_cnt[i] = 8'h00;
    rst = 1'b1; req = 3'b000; last = 3'b000; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_single_lane2();
    test_zero_extend();
    test_round_robin();
    test_burst_max();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
